// File: rtl/iiitb_aclock.sv
// ============================================================================
// Module      : iiitb_aclock
// Description : 24-hour BCD alarm clock with a divided one-second tick,
//               loadable time/alarm and a sticky, edge-triggered Alarm output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iiitb_aclock #(
    parameter int CLK_PER_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       LD_time,
    input  logic       LD_alarm,
    input  logic       STOP_al,
    input  logic       AL_ON,
    output logic       Alarm,
    output logic [1:0] H_out1,
    output logic [3:0] H_out0,
    output logic [3:0] M_out1,
    output logic [3:0] M_out0,
    output logic [3:0] S_out1,
    output logic [3:0] S_out0
);

    localparam int unsigned c_div_w = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_PER_SEC - 1);

    logic [c_div_w-1:0] r_div;
    logic [4:0]         r_hours;
    logic [5:0]         r_minutes;
    logic [5:0]         r_seconds;
    logic [4:0]         r_al_hours;
    logic [5:0]         r_al_minutes;
    logic               r_match_d;
    logic               r_alarm;

    logic [5:0] w_ld_hours_raw;
    logic [7:0] w_ld_minutes_raw;
    logic [4:0] w_ld_hours;
    logic [5:0] w_ld_minutes;
    logic       w_tick;
    logic       w_match;

    // Out-of-range entries collapse to zero rather than wrapping modulo.
    assign w_ld_hours_raw   = 6'(H_in1) * 6'd10 + 6'(H_in0);
    assign w_ld_minutes_raw = 8'(M_in1) * 8'd10 + 8'(M_in0);
    assign w_ld_hours       = (w_ld_hours_raw < 6'd24) ? w_ld_hours_raw[4:0] : 5'd0;
    assign w_ld_minutes     = (w_ld_minutes_raw < 8'd60) ? w_ld_minutes_raw[5:0] : 6'd0;

    assign w_tick  = (r_div == c_div_max);
    assign w_match = (r_hours == r_al_hours) && (r_minutes == r_al_minutes) &&
                     (r_seconds == 6'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_seconds <= 6'd0;
            r_hours   <= w_ld_hours;
            r_minutes <= w_ld_minutes;
        end else if (LD_time) begin
            r_div     <= '0;
            r_seconds <= 6'd0;
            r_hours   <= w_ld_hours;
            r_minutes <= w_ld_minutes;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                if (r_seconds == 6'd59) begin
                    r_seconds <= 6'd0;
                    if (r_minutes == 6'd59) begin
                        r_minutes <= 6'd0;
                        r_hours   <= (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
                    end else begin
                        r_minutes <= r_minutes + 6'd1;
                    end
                end else begin
                    r_seconds <= r_seconds + 6'd1;
                end
            end
        end
    end

    // Alarm fires only on the rising edge of match, so releasing STOP_al
    // during the matching second does not re-arm it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_al_hours   <= 5'd0;
            r_al_minutes <= 6'd0;
            r_match_d    <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            if (LD_alarm) begin
                r_al_hours   <= w_ld_hours;
                r_al_minutes <= w_ld_minutes;
            end
            r_match_d <= w_match;
            if (STOP_al || !AL_ON) begin
                r_alarm <= 1'b0;
            end else if (w_match && !r_match_d) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign Alarm  = r_alarm;
    assign H_out1 = 2'(r_hours / 5'd10);
    assign H_out0 = 4'(r_hours % 5'd10);
    assign M_out1 = 4'(r_minutes / 6'd10);
    assign M_out0 = 4'(r_minutes % 6'd10);
    assign S_out1 = 4'(r_seconds / 6'd10);
    assign S_out0 = 4'(r_seconds % 6'd10);

endmodule

`default_nettype wire

// File: tb/tb_iiitb_aclock.sv
// ============================================================================
// Module      : tb_iiitb_aclock
// Description : Directed, table-driven self-checking bench for iiitb_aclock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iiitb_aclock;

    logic       clk;
    logic       reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       STOP_al;
    logic       AL_ON;
    logic       Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0;
    logic [3:0] M_out1;
    logic [3:0] M_out0;
    logic [3:0] S_out1;
    logic [3:0] S_out0;

    int checks = 0;
    int errors = 0;

    iiitb_aclock #(.CLK_PER_SEC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .H_in1    (H_in1),
        .H_in0    (H_in0),
        .M_in1    (M_in1),
        .M_in0    (M_in0),
        .LD_time  (LD_time),
        .LD_alarm (LD_alarm),
        .STOP_al  (STOP_al),
        .AL_ON    (AL_ON),
        .Alarm    (Alarm),
        .H_out1   (H_out1),
        .H_out0   (H_out0),
        .M_out1   (M_out1),
        .M_out0   (M_out0),
        .S_out1   (S_out1),
        .S_out0   (S_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        int         eh;
        int         em;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [21:0] bcd_time(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [21:0] cur_time();
        return {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check(name, {10'd0, cur_time()}, {10'd0, bcd_time(h, m, s)});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
        H_in1 = h1;
        H_in0 = h0;
        M_in1 = m1;
        M_in0 = m0;
    endtask

    task automatic load(input logic t, input logic a);
        LD_time  = t;
        LD_alarm = a;
        step(1);
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
    endtask

    task automatic wait_time(input string name, input int h, input int m, input int s,
                             input int bound);
        int n;
        n = 0;
        while (cur_time() !== bcd_time(h, m, s) && n < bound) begin
            step(1);
            n++;
        end
        check(name, {10'd0, cur_time()}, {10'd0, bcd_time(h, m, s)});
    endtask

    initial begin
        vecs[0] = '{2'd1, 4'd0, 4'd1, 4'd4, 10, 14};
        vecs[1] = '{2'd2, 4'd3, 4'd5, 4'd9, 23, 59};
        vecs[2] = '{2'd2, 4'd4, 4'd0, 4'd0,  0,  0};
        vecs[3] = '{2'd2, 4'd5, 4'd6, 4'd1,  0,  0};
        vecs[4] = '{2'd0, 4'd9, 4'd5, 4'd9,  9, 59};
        vecs[5] = '{2'd3, 4'd15, 4'd15, 4'd15, 0, 0};
        vecs[6] = '{2'd1, 4'd15, 4'd0, 4'd0,  0,  0};
        vecs[7] = '{2'd0, 4'd0, 4'd6, 4'd0,  0,  0};
        vecs[8] = '{2'd1, 4'd9, 4'd1, 4'd2, 19, 12};
        vecs[9] = '{2'd2, 4'd0, 4'd15, 4'd15, 20, 0};

        reset    = 1'b1;
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
        STOP_al  = 1'b0;
        AL_ON    = 1'b0;
        set_in(2'd1, 4'd0, 4'd1, 4'd4);

        // Reset loads the time from the inputs.
        #2;
        check_time("reset_async_time", 10, 14, 0);
        step(10);
        check("reset_alarm", {31'd0, Alarm}, 32'd0);
        reset = 1'b0;
        step(1);
        check_time("post_reset_time", 10, 14, 0);
        step(8);
        check_time("before_first_tick", 10, 14, 0);
        step(1);
        check_time("first_tick", 10, 14, 1);
        step(590);
        check_time("after_600_clk", 10, 15, 0);

        // Alarm at 10:20, then STOP_al during the matching second.
        AL_ON = 1'b1;
        set_in(2'd1, 4'd0, 4'd2, 4'd0);
        LD_alarm = 1'b1;
        step(10);
        LD_alarm = 1'b0;
        check("alarm_idle_after_load", {31'd0, Alarm}, 32'd0);
        wait_time("reach_10_20", 10, 20, 0, 4000);
        check("alarm_same_edge", {31'd0, Alarm}, 32'd0);
        step(1);
        check("alarm_rise_10_20", {31'd0, Alarm}, 32'd1);
        STOP_al = 1'b1;
        step(1);
        check("stop_clears", {31'd0, Alarm}, 32'd0);
        STOP_al = 1'b0;
        step(5);
        check_time("still_matching_second", 10, 20, 0);
        check("no_retrigger", {31'd0, Alarm}, 32'd0);

        // Time load restarts the divider; re-arm at 04:55.
        set_in(2'd0, 4'd4, 4'd4, 4'd5);
        load(1'b1, 1'b0);
        check_time("ld_time_0445", 4, 45, 0);
        step(9);
        check_time("div_restart_hold", 4, 45, 0);
        step(1);
        check_time("div_restart_tick", 4, 45, 1);
        set_in(2'd0, 4'd4, 4'd5, 4'd5);
        load(1'b0, 1'b1);
        wait_time("reach_04_55", 4, 55, 0, 7000);
        check("alarm_same_edge_0455", {31'd0, Alarm}, 32'd0);
        step(1);
        check("alarm_rise_0455", {31'd0, Alarm}, 32'd1);
        step(100);
        check_time("time_04_55_10", 4, 55, 10);
        check("alarm_sticky", {31'd0, Alarm}, 32'd1);
        AL_ON = 1'b0;
        step(1);
        check("al_on_low_clears", {31'd0, Alarm}, 32'd0);

        // Midnight wrap.
        set_in(2'd2, 4'd3, 4'd5, 4'd9);
        load(1'b1, 1'b0);
        check_time("ld_2359", 23, 59, 0);
        step(599);
        check_time("pre_wrap", 23, 59, 59);
        step(1);
        check_time("wrap_midnight", 0, 0, 0);

        // Load sanitising table.
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].h1, vecs[i].h0, vecs[i].m1, vecs[i].m0);
            load(1'b1, 1'b0);
            check_time($sformatf("table_ld_%0d", i), vecs[i].eh, vecs[i].em, 0);
        end

        // Simultaneous loads of 25:61 both sanitise to 00:00 and match.
        AL_ON = 1'b1;
        set_in(2'd2, 4'd5, 4'd6, 4'd1);
        load(1'b1, 1'b1);
        check_time("both_ld_2561", 0, 0, 0);
        check("both_ld_same_edge", {31'd0, Alarm}, 32'd0);
        step(1);
        check("both_ld_alarm_rise", {31'd0, Alarm}, 32'd1);
        AL_ON = 1'b0;
        step(1);
        check("both_ld_al_off", {31'd0, Alarm}, 32'd0);

        // Disabled alarm reaching its time stays quiet.
        set_in(2'd1, 4'd1, 4'd5, 4'd9);
        load(1'b1, 1'b0);
        set_in(2'd1, 4'd2, 4'd0, 4'd0);
        load(1'b0, 1'b1);
        step(599);
        check_time("reach_12_00", 12, 0, 0);
        step(10);
        check("disabled_no_alarm", {31'd0, Alarm}, 32'd0);

        // Load that creates a match, then async reset while Alarm is high.
        AL_ON = 1'b1;
        set_in(2'd0, 4'd7, 4'd3, 4'd0);
        load(1'b1, 1'b1);
        check("ld_match_same_edge", {31'd0, Alarm}, 32'd0);
        step(1);
        check("ld_match_rise", {31'd0, Alarm}, 32'd1);
        reset = 1'b1;
        #2;
        check("reset_async_alarm", {31'd0, Alarm}, 32'd0);
        check_time("reset_async_0730", 7, 30, 0);
        step(2);
        reset = 1'b0;
        step(1);
        check_time("post_reset_0730", 7, 30, 0);
        check("post_reset_alarm", {31'd0, Alarm}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
